conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequences the convolution PE inside the execute stage for one CONV command: latches base
//  vector-register addresses, window count and stride, drives conv_en/strd_cyc and vA/vB
//  read addresses window by window, and counts PE results to generate write-back addresses.
//  Holds the pipeline stalled until every issued window's result has been written back.
// PARAMETERS
//  VREG_AW   5   vector register file address width (32 vector registers)
//  CNT_W     8   window counter width (max 2^CNT_W-1 windows per command)
//  MAX_OUT   4   max windows in flight in the PE before issue pauses
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  reset      in   1        synchronous, active-high
//  start      in   1        1-cycle command strobe; ignored while busy
//  cfg_rA     in   VREG_AW  feature base vreg
//  cfg_rB     in   VREG_AW  kernel base vreg
//  cfg_rD     in   VREG_AW  destination base vreg
//  cfg_win    in   CNT_W    number of windows
//  cfg_strd   in   3        cycles per window (strd_cyc); 0 treated as 1
//  pe_out_en  in   1        PE result-valid (out_conv_en), one pulse per window
//  conv_en    out  1        PE accumulate enable
//  strd_cyc   out  3        latched stride to PE
//  va_addr    out  VREG_AW  feature vreg read address
//  vb_addr    out  VREG_AW  kernel vreg read address
//  wr_en      out  1        result write strobe (= pe_out_en while busy)
//  wr_addr    out  VREG_AW  result destination vreg
//  busy       out  1        command active; used as pipeline stall
//  done       out  1        1-cycle pulse when last result written
//  err        out  1        sticky: pe_out_en with nothing outstanding; cleared by reset/start
// BEHAVIOUR
//  - Reset: state IDLE; conv_en, wr_en, busy, done, err = 0; strd_cyc = 1; addrs = 0; counters 0.
//  - IDLE: on start, latch cfg_* (stride 0 -> 1), clear err; cfg_win==0 -> DONE next cycle,
//    else ISSUE. Latch-to-first conv_en latency: 1 cycle.
//  - ISSUE: conv_en=1 each cycle; cyc counts 0..strd-1; va_addr = cfg_rA + issue_idx*strd + cyc,
//    vb_addr = cfg_rB + cyc (kernel reused each window). All address sums wrap mod 2^VREG_AW.
//    At cyc==strd-1: win_issued++, outstanding++. If outstanding would reach MAX_OUT, deassert
//    conv_en (PAUSE) until a pe_out_en frees a slot. After last window -> DRAIN.
//  - DRAIN: conv_en=0; wait until outstanding==0 -> DONE.
//  - DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
//  - Results: on pe_out_en while busy, wr_en=1 same cycle, wr_addr = cfg_rD + res_idx, res_idx++,
//    outstanding--. Window end and pe_out_en in the same cycle: outstanding unchanged.
//  - pe_out_en with outstanding==0 or while IDLE: no write, err set.
//  - busy high from cycle after start through DONE cycle inclusive.
//  - reset mid-command: immediate return to IDLE, no done pulse, outstanding discarded.
// CONFIGURATION
//  CONV_SEQ_ABORT_EN defined: adds input abort (1); abort while ISSUE/PAUSE stops issue at
//   once (partial window dropped, not counted), goes to DRAIN, done still pulses after
//   outstanding results are written. abort in IDLE/DONE ignored.
//  Undefined: no abort port; command always runs to completion.
// STRUCTURE
//  Shared package/include (def.v): VREG_AW default, state encodings
//  CSQ_IDLE/ISSUE/PAUSE/DRAIN/DONE, stride width 3. One sub-module natural: conv_seq_addr_gen
//  (va/vb/wr address adders with wrap); FSM and counters stay in top.
// TESTING
//  1. win=3, strd=3, rA=0, rB=8, rD=16, PE lat 2 -> conv_en 9 cycles; va 0..8; vb 8,9,10 x3;
//     wr_addr 16,17,18; one done pulse; busy falls after done.
//  2. win=0 -> no conv_en, no wr_en, done 2 cycles after start.
//  3. rA=30, strd=2, win=2, rD=31 -> va 30,31,0,1; wr_addr 31,0 (wrap).
//  4. PE lat 20, win=6, MAX_OUT=4 -> conv_en pauses after 4th window, resumes per result;
//     done only after 6th wr_en.
//  5. pe_out_en in IDLE -> err=1, wr_en=0; next start clears err. start while busy ignored.
//  6. reset mid-ISSUE -> next cycle busy=0, conv_en=0, no done; with CONV_SEQ_ABORT_EN,
//     abort at window 2 of 5 -> done after outstanding drained, exactly 2 writes.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared widths, limits and FSM encoding for the CONV sequencer.
// Optional abort input is enabled with CONV_SEQ_ABORT_EN (see conv_seq_ctrl.sv).
package conv_seq_ctrl_pkg;
   localparam int VREG_AW = 5;
   localparam int CNT_W   = 8;
   localparam int MAX_OUT = 4;
   localparam int STRD_W  = 3;
   localparam int OUT_W   = $clog2(MAX_OUT + 1);

   typedef logic [VREG_AW-1:0] vreg_addr_t;
   typedef logic [CNT_W-1:0]   win_cnt_t;
   typedef logic [STRD_W-1:0]  strd_t;
   typedef logic [OUT_W-1:0]   out_cnt_t;

   typedef enum logic [2:0] {
      CSQ_IDLE,
      CSQ_ISSUE,
      CSQ_PAUSE,
      CSQ_DRAIN,
      CSQ_DONE
   } csq_state_e;

   // A zero stride would never end a window, so it behaves as one cycle per window.
   function automatic strd_t norm_strd(input strd_t s);
      return (s == '0) ? strd_t'(1) : s;
   endfunction
endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Command, PE and write-back signals of the CONV sequencer.
// The abort input exists only when CONV_SEQ_ABORT_EN is defined.
interface conv_seq_ctrl_if;
   import conv_seq_ctrl_pkg::*;

   logic       start;
   vreg_addr_t cfg_rA;
   vreg_addr_t cfg_rB;
   vreg_addr_t cfg_rD;
   win_cnt_t   cfg_win;
   strd_t      cfg_strd;
   logic       pe_out_en;
`ifdef CONV_SEQ_ABORT_EN
   logic       abort;
`endif
   logic       conv_en;
   strd_t      strd_cyc;
   vreg_addr_t va_addr;
   vreg_addr_t vb_addr;
   logic       wr_en;
   vreg_addr_t wr_addr;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start, cfg_rA, cfg_rB, cfg_rD, cfg_win, cfg_strd, pe_out_en,
`ifdef CONV_SEQ_ABORT_EN
      output abort,
`endif
      input  conv_en, strd_cyc, va_addr, vb_addr, wr_en, wr_addr, busy, done, err
   );

   modport slave (
      input  start, cfg_rA, cfg_rB, cfg_rD, cfg_win, cfg_strd, pe_out_en,
`ifdef CONV_SEQ_ABORT_EN
      input  abort,
`endif
      output conv_en, strd_cyc, va_addr, vb_addr, wr_en, wr_addr, busy, done, err
   );
endinterface

// File: rtl/conv_seq_ctrl_addr_gen.sv
// Vector-register address adders for the CONV sequencer; every sum wraps
// modulo 2^VREG_AW because results are truncated to the address width.
module conv_seq_ctrl_addr_gen
   import conv_seq_ctrl_pkg::*;
(
   input  vreg_addr_t va_base,
   input  vreg_addr_t rb_base,
   input  vreg_addr_t rd_base,
   input  strd_t      strd,
   input  strd_t      cyc,
   input  vreg_addr_t res_idx,
   output vreg_addr_t va_rd,
   output vreg_addr_t vb_rd,
   output vreg_addr_t va_base_nxt,
   output vreg_addr_t wr_addr
);
   assign va_rd       = va_base + vreg_addr_t'(cyc);
   assign vb_rd       = rb_base + vreg_addr_t'(cyc);
   assign va_base_nxt = va_base + vreg_addr_t'(strd);
   assign wr_addr     = rd_base + res_idx;
endmodule

// File: rtl/conv_seq_ctrl.sv
// CONV command sequencer: issues PE windows, bounds results in flight, stalls until write-back.
// Define CONV_SEQ_ABORT_EN to add the abort input that cuts issue short and drains.
module conv_seq_ctrl
   import conv_seq_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   conv_seq_ctrl_if.slave bus
);
   csq_state_e state_q;
   vreg_addr_t va_base_q, rb_q, rd_q, va_q, vb_q;
   win_cnt_t   win_q, win_issued_q, res_idx_q;
   strd_t      strd_q, cyc_q;
   out_cnt_t   outstanding_q, out_nxt;
   logic       conv_en_q, busy_q, done_q, err_q;
   logic       abort_req, accept, issuing, win_end, last_win, wr;
   vreg_addr_t va_rd, vb_rd, va_base_nxt, wr_addr;

`ifdef CONV_SEQ_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   // busy_q still reads high in the cycle after DONE, so start is ignored there too.
   assign accept   = (state_q == CSQ_IDLE) && !busy_q && bus.start;
   assign wr       = bus.pe_out_en && (state_q != CSQ_IDLE) && (outstanding_q != '0);
   assign issuing  = (state_q == CSQ_ISSUE) && !abort_req;
   assign win_end  = issuing && (cyc_q == strd_q - strd_t'(1));
   assign last_win = (win_issued_q == win_q - win_cnt_t'(1));
   assign out_nxt  = outstanding_q + out_cnt_t'(win_end) - out_cnt_t'(wr);

   conv_seq_ctrl_addr_gen u_addr_gen (
      .va_base     (va_base_q),
      .rb_base     (rb_q),
      .rd_base     (rd_q),
      .strd        (strd_q),
      .cyc         (cyc_q),
      .res_idx     (vreg_addr_t'(res_idx_q)),
      .va_rd       (va_rd),
      .vb_rd       (vb_rd),
      .va_base_nxt (va_base_nxt),
      .wr_addr     (wr_addr)
   );

   // Outputs are registered from the current state, so they trail it by one cycle.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= CSQ_IDLE;
         va_base_q     <= '0;
         rb_q          <= '0;
         rd_q          <= '0;
         va_q          <= '0;
         vb_q          <= '0;
         win_q         <= '0;
         win_issued_q  <= '0;
         res_idx_q     <= '0;
         strd_q        <= strd_t'(1);
         cyc_q         <= '0;
         outstanding_q <= '0;
         conv_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         conv_en_q     <= 1'b0;
         done_q        <= (state_q == CSQ_DONE);
         busy_q        <= (state_q != CSQ_IDLE) || accept;
         outstanding_q <= out_nxt;
         if (wr) res_idx_q <= res_idx_q + win_cnt_t'(1);

         case (state_q)
            CSQ_IDLE: begin
               if (accept) begin
                  va_base_q    <= bus.cfg_rA;
                  rb_q         <= bus.cfg_rB;
                  rd_q         <= bus.cfg_rD;
                  win_q        <= bus.cfg_win;
                  strd_q       <= norm_strd(bus.cfg_strd);
                  cyc_q        <= '0;
                  win_issued_q <= '0;
                  res_idx_q    <= '0;
                  err_q        <= 1'b0;
                  state_q      <= (bus.cfg_win == '0) ? CSQ_DONE : CSQ_ISSUE;
               end
            end
            CSQ_ISSUE: begin
               if (abort_req) begin
                  // The partially issued window is dropped and never counted.
                  cyc_q   <= '0;
                  state_q <= CSQ_DRAIN;
               end else begin
                  conv_en_q <= 1'b1;
                  va_q      <= va_rd;
                  vb_q      <= vb_rd;
                  if (win_end) begin
                     cyc_q        <= '0;
                     win_issued_q <= win_issued_q + win_cnt_t'(1);
                     va_base_q    <= va_base_nxt;
                     if (last_win)                              state_q <= CSQ_DRAIN;
                     else if (out_nxt >= out_cnt_t'(MAX_OUT))   state_q <= CSQ_PAUSE;
                  end else begin
                     cyc_q <= cyc_q + strd_t'(1);
                  end
               end
            end
            CSQ_PAUSE: begin
               if (abort_req)                         state_q <= CSQ_DRAIN;
               else if (out_nxt < out_cnt_t'(MAX_OUT)) state_q <= CSQ_ISSUE;
            end
            CSQ_DRAIN: begin
               if (outstanding_q == '0) state_q <= CSQ_DONE;
            end
            CSQ_DONE: state_q <= CSQ_IDLE;
            default:  state_q <= CSQ_IDLE;
         endcase

         // A result with nothing outstanding is a protocol error; set wins over the start clear.
         if (bus.pe_out_en && !wr) err_q <= 1'b1;
      end
   end

   assign bus.conv_en  = conv_en_q;
   assign bus.strd_cyc = strd_q;
   assign bus.va_addr  = va_q;
   assign bus.vb_addr  = vb_q;
   assign bus.wr_en    = wr;
   assign bus.wr_addr  = wr_addr;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: queue model of expected beats and write addresses.
// The abort scenario runs only when CONV_SEQ_ABORT_EN is defined.
module tb_conv_seq_ctrl;
   import conv_seq_ctrl_pkg::*;

   typedef struct {
      int va;
      int vb;
   } beat_t;

   localparam int AMOD = 1 << VREG_AW;

   logic clk = 1'b0;
   logic reset;
   logic pe_manual = 1'b0;

   conv_seq_ctrl_if bus ();
   conv_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc_n = 0;
   beat_t exp_beats[$];
   beat_t cmp_beat;
   int    exp_wr[$];
   int    res_due[$];
   int    wr_log[$];
   int    va_log[$];
   int    vb_log[$];
   int    exp_writes, exp_strd = 1, pe_lat = 1;
   int    beats_seen, wins_seen, writes_seen, max_inflight;
   int    done_seen, done_cyc, first_conv_cyc, start_cyc, junk_cyc;
   logic  busy_at_done;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // PE stand-in: one result per completed window, pe_lat cycles after its last beat.
   always @(posedge clk) begin
      #1;
      if (reset === 1'b1) res_due.delete();
      bus.pe_out_en = pe_manual;
      if (res_due.size() > 0 && res_due[0] == cyc_n) begin
         void'(res_due.pop_front());
         bus.pe_out_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (bus.conv_en === 1'b1) begin
            if (first_conv_cyc < 0) first_conv_cyc = cyc_n;
            va_log.push_back(int'(bus.va_addr));
            vb_log.push_back(int'(bus.vb_addr));
            if (exp_beats.size() == 0) check("conv_en_unexpected", 1, 0);
            else begin
               cmp_beat = exp_beats.pop_front();
               check("va_addr", bus.va_addr, cmp_beat.va);
               check("vb_addr", bus.vb_addr, cmp_beat.vb);
               check("strd_cyc", bus.strd_cyc, exp_strd);
            end
            beats_seen++;
            if (beats_seen % exp_strd == 0) begin
               wins_seen++;
               res_due.push_back(cyc_n + pe_lat);
               if (wins_seen - writes_seen > max_inflight) max_inflight = wins_seen - writes_seen;
               check("inflight_within_max", (wins_seen - writes_seen) <= MAX_OUT, 1);
            end
         end
         if (bus.wr_en === 1'b1) begin
            wr_log.push_back(int'(bus.wr_addr));
            if (exp_wr.size() == 0) check("wr_en_unexpected", 1, 0);
            else check("wr_addr", bus.wr_addr, exp_wr.pop_front());
            writes_seen++;
         end
         if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc     = cyc_n;
            busy_at_done = bus.busy;
         end
      end
   end

   task automatic load_model(input int ra, input int rb, input int rd,
                             input int win, input int strd, input int lat);
      beat_t nb;
      int s;
      s = (strd == 0) ? 1 : strd;
      exp_beats.delete(); exp_wr.delete(); res_due.delete();
      wr_log.delete(); va_log.delete(); vb_log.delete();
      for (int w = 0; w < win; w++)
         for (int c = 0; c < s; c++) begin
            nb.va = (ra + w * s + c) % AMOD;
            nb.vb = (rb + c) % AMOD;
            exp_beats.push_back(nb);
         end
      for (int i = 0; i < win; i++) exp_wr.push_back((rd + i) % AMOD);
      exp_writes = win;     exp_strd = s;       pe_lat = lat;
      beats_seen = 0;       wins_seen = 0;      writes_seen = 0;
      max_inflight = 0;     done_seen = 0;      first_conv_cyc = -1;
   endtask

   task automatic pulse_start(input int ra, input int rb, input int rd,
                              input int win, input int strd, output int c);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.cfg_rA   = vreg_addr_t'(ra);
      bus.cfg_rB   = vreg_addr_t'(rb);
      bus.cfg_rD   = vreg_addr_t'(rd);
      bus.cfg_win  = win_cnt_t'(win);
      bus.cfg_strd = strd_t'(strd);
      c = cyc_n;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic start_cmd(input int ra, input int rb, input int rd,
                            input int win, input int strd, input int lat);
      load_model(ra, rb, rd, win, strd, lat);
      pulse_start(ra, rb, rd, win, strd, start_cyc);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_seen == 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_done_seen"}, done_seen, 1);
      check({tag, "_writes_at_done"}, writes_seen, exp_writes);
      check({tag, "_busy_at_done"}, busy_at_done, 1);
      @(negedge clk);
      check({tag, "_busy_after_done"}, bus.busy, 0);
      check({tag, "_done_one_cycle"}, bus.done, 0);
      check({tag, "_single_done"}, done_seen, 1);
   endtask

   initial begin
      int n;
      bus.start = 1'b0;   bus.cfg_rA = '0;  bus.cfg_rB = '0;   bus.cfg_rD = '0;
      bus.cfg_win = '0;   bus.cfg_strd = '0;
`ifdef CONV_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      load_model(0, 0, 0, 0, 1, 1);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bus.busy, 0);         check("rst_conv_en", bus.conv_en, 0);
      check("rst_done", bus.done, 0);         check("rst_err", bus.err, 0);
      check("rst_wr_en", bus.wr_en, 0);       check("rst_strd_cyc", bus.strd_cyc, 1);
      check("rst_va", bus.va_addr, 0);        check("rst_vb", bus.vb_addr, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      @(posedge clk); #1 reset = 1'b0;

      // 1: three windows of stride 3, PE latency 2
      start_cmd(0, 8, 16, 3, 3, 2);
      wait_done("t1");
      check("t1_beats", beats_seen, 9);
      check("t1_first_conv_lat", first_conv_cyc - start_cyc, 2);
      check("t1_wr_count", wr_log.size(), 3);
      if (va_log.size() == 9) begin
         check("t1_va_first", va_log[0], 0);  check("t1_va_last", va_log[8], 8);
         check("t1_vb_6th", vb_log[5], 10);   check("t1_vb_7th", vb_log[6], 8);
      end
      if (wr_log.size() == 3) begin
         check("t1_wr0", wr_log[0], 16); check("t1_wr1", wr_log[1], 17); check("t1_wr2", wr_log[2], 18);
      end

      // 2: empty command
      start_cmd(3, 4, 5, 0, 2, 1);
      wait_done("t2");
      check("t2_beats", beats_seen, 0);
      check("t2_done_lat", done_cyc - start_cyc, 2);

      // 3: address wrap on va and wr
      start_cmd(30, 0, 31, 2, 2, 1);
      wait_done("t3");
      check("t3_beats", va_log.size(), 4);
      if (va_log.size() == 4) begin
         check("t3_va0", va_log[0], 30); check("t3_va1", va_log[1], 31);
         check("t3_va2", va_log[2], 0);  check("t3_va3", va_log[3], 1);
      end
      if (wr_log.size() == 2) begin
         check("t3_wr0", wr_log[0], 31); check("t3_wr1", wr_log[1], 0);
      end

      // 3b: stride 0 behaves as stride 1
      start_cmd(5, 1, 2, 2, 0, 1);
      wait_done("t3b");
      check("t3b_beats", beats_seen, 2);

      // 4: long PE latency forces issue to pause at MAX_OUT windows in flight
      start_cmd(0, 0, 0, 6, 2, 20);
      wait_done("t4");
      check("t4_max_inflight", max_inflight, 4);
      check("t4_beats", beats_seen, 12);

      // 5: stray result in IDLE, then err cleared by start; start while busy ignored
      @(negedge clk) pe_manual = 1'b1;
      @(negedge clk);
      check("t5_stray_wr_en", bus.wr_en, 0);
      pe_manual = 1'b0;
      @(negedge clk);
      check("t5_err_set", bus.err, 1);
      start_cmd(10, 20, 3, 4, 2, 3);
      @(negedge clk);
      check("t5_err_cleared", bus.err, 0);
      repeat (2) @(posedge clk);
      pulse_start(1, 1, 1, 9, 1, junk_cyc);
      wait_done("t5");
      check("t5_err_end", bus.err, 0);

      // 6: synchronous reset in the middle of issue
      start_cmd(0, 0, 0, 5, 3, 2);
      n = 0;
      while (beats_seen < 4 && n < 100) begin @(posedge clk); n++; end
      check("t6_reached_issue", beats_seen >= 4, 1);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      exp_beats.delete(); exp_wr.delete();
      n = done_seen;
      @(negedge clk);
      check("t6_busy_after_rst", bus.busy, 0);
      check("t6_conv_en_after_rst", bus.conv_en, 0);
      repeat (10) @(negedge clk);
      check("t6_no_done", done_seen, n);
      check("t6_no_err", bus.err, 0);

`ifdef CONV_SEQ_ABORT_EN
      // 6b: abort during the third window drains the two completed windows
      start_cmd(0, 0, 4, 5, 3, 2);
      n = 0;
      while (beats_seen < 7 && n < 100) begin @(posedge clk); n++; end
      #1 bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      exp_writes = 2;
      wait_done("t6b");
      check("t6b_partial_window", beats_seen < 9, 1);
      if (wr_log.size() == 2) begin
         check("t6b_wr0", wr_log[0], 4); check("t6b_wr1", wr_log[1], 5);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
